// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and defaults for the DE2-115 SRAM arbiter.
//   - arbState_t : sequencer states (idle, write slot, read slot, turnaround)
//   - arbPort_t  : requester selector used by the pick logic and grant history
//   - ADDR_W_DEF / DATA_W_DEF : default SRAM word address and data widths
package sram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 18;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ACC  = 3'd1,
    WR_HOLD = 3'd2,
    TURN    = 3'd3,
    RD_ACC  = 3'd4,
    RD_HOLD = 3'd5
  } arbState_t;

  typedef enum logic {
    PORT_WR = 1'b0,
    PORT_RD = 1'b1
  } arbPort_t;

endpackage : sram_arb_pkg

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: combinational two-way pick between the write and read ports.
// Build option: SRAM_ARB_WR_PRIORITY_EN -> write always wins a tie;
// otherwise a tie goes to the port that was not granted last.
// Ports:
//   wrReq, rdReq  : pending requests
//   lastGrant     : port granted most recently
//   grantValid_c  : at least one request pending
//   grantPort_c   : selected port (meaningful when grantValid_c)
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic     wrReq,
  input  logic     rdReq,
  input  arbPort_t lastGrant,
  output logic     grantValid_c,
  output arbPort_t grantPort_c
);

`ifdef SRAM_ARB_WR_PRIORITY_EN
  // Grant history is irrelevant with fixed priority.
  logic unusedLastGrant;
  assign unusedLastGrant = ^lastGrant;
`endif

  always_comb begin
    grantValid_c = wrReq | rdReq;
    grantPort_c  = PORT_WR;
    if (wrReq && rdReq) begin
`ifdef SRAM_ARB_WR_PRIORITY_EN
      grantPort_c = PORT_WR;
`else
      grantPort_c = (lastGrant == PORT_RD) ? PORT_WR : PORT_RD;
`endif
    end else if (rdReq) begin
      grantPort_c = PORT_RD;
    end
  end

endmodule : sram_arb_pick

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the single-port SRAM interface block between a write
// requester (camera capture) and a read requester (display/processing).
// Every granted access is a two-cycle slot (ACC + HOLD); a write followed
// directly by a read gets one TURN cycle in between.
// Build option: SRAM_ARB_WR_PRIORITY_EN (fixed write priority on ties);
// default build is round-robin.
// Ports:
//   iCLK, iRST                    : clock, synchronous active-high reset
//   iWrReq/iWrAddr/iWrData/oWrAck : write requester handshake
//   iRdReq/iRdAddr/oRdAck         : read requester handshake
//   oRdData/oRdValid              : returned read data, one-cycle valid pulse
//   oControlState                 : 1 = write in this slot (to interface)
//   oMemoryWriteAddress/oMemoryReadAddress/oMemoryData : to interface
//   iMemoryData                   : registered read data from interface
//   oBusy                         : sequencer not idle
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iWrReq,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [DATA_W-1:0] iWrData,
  output logic              oWrAck,
  input  logic              iRdReq,
  input  logic [ADDR_W-1:0] iRdAddr,
  output logic              oRdAck,
  output logic [DATA_W-1:0] oRdData,
  output logic              oRdValid,
  output logic              oControlState,
  output logic [ADDR_W-1:0] oMemoryWriteAddress,
  output logic [ADDR_W-1:0] oMemoryReadAddress,
  output logic [DATA_W-1:0] oMemoryData,
  input  logic [DATA_W-1:0] iMemoryData,
  output logic              oBusy
);

  arbState_t state;
  arbState_t stateNext;
  arbPort_t  lastGrant;
  arbPort_t  lastGrantNext;

  logic      grantValid_c;
  arbPort_t  grantPort_c;

  logic              ctrlNext;
  logic              wrAckNext;
  logic              rdAckNext;
  logic              rdValidNext;
  logic              busyNext;
  logic [ADDR_W-1:0] wrAddrNext;
  logic [ADDR_W-1:0] rdAddrNext;
  logic [DATA_W-1:0] wrDataNext;
  logic [DATA_W-1:0] rdDataNext;

  // Tie-break between the two requesters.
  sram_arb_pick uPick (
    .wrReq        (iWrReq),
    .rdReq        (iRdReq),
    .lastGrant    (lastGrant),
    .grantValid_c (grantValid_c),
    .grantPort_c  (grantPort_c)
  );

  // State and grant-history register; history resets to "read" so write wins
  // the first tie.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= IDLE;
      lastGrant <= PORT_RD;
    end else begin
      state     <= stateNext;
      lastGrant <= lastGrantNext;
    end
  end

  // Next state plus the values the output registers take on the next edge.
  always_comb begin
    stateNext     = state;
    lastGrantNext = lastGrant;
    ctrlNext      = 1'b0;
    wrAckNext     = 1'b0;
    rdAckNext     = 1'b0;
    rdValidNext   = 1'b0;
    wrAddrNext    = oMemoryWriteAddress;
    rdAddrNext    = oMemoryReadAddress;
    wrDataNext    = oMemoryData;
    rdDataNext    = oRdData;

    case (state)
      IDLE, WR_HOLD, RD_HOLD: begin
        if (grantValid_c) begin
          lastGrantNext = grantPort_c;
          if (grantPort_c == PORT_WR) begin
            stateNext = WR_ACC;
          end else if (state == WR_HOLD) begin
            // Write-to-read needs a dead cycle for bus turnaround.
            stateNext = TURN;
          end else begin
            stateNext = RD_ACC;
          end
        end else begin
          stateNext = IDLE;
        end
      end
      WR_ACC:  stateNext = WR_HOLD;
      TURN:    stateNext = RD_ACC;
      RD_ACC:  stateNext = RD_HOLD;
      default: stateNext = IDLE;
    endcase

    // Interface returns read data during RD_HOLD; capture it here.
    if (state == RD_HOLD) begin
      rdValidNext = 1'b1;
      rdDataNext  = iMemoryData;
    end

    // Address/data are loaded only on entry to an access slot and held after.
    if (stateNext == WR_ACC) begin
      ctrlNext   = 1'b1;
      wrAckNext  = 1'b1;
      wrAddrNext = iWrAddr;
      wrDataNext = iWrData;
    end else if (stateNext == RD_ACC) begin
      rdAckNext  = 1'b1;
      rdAddrNext = iRdAddr;
    end

    busyNext = (stateNext != IDLE);
  end

  // Output registers.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oControlState       <= 1'b0;
      oWrAck              <= 1'b0;
      oRdAck              <= 1'b0;
      oRdValid            <= 1'b0;
      oBusy               <= 1'b0;
      oMemoryWriteAddress <= '0;
      oMemoryReadAddress  <= '0;
      oMemoryData         <= '0;
      oRdData             <= '0;
    end else begin
      oControlState       <= ctrlNext;
      oWrAck              <= wrAckNext;
      oRdAck              <= rdAckNext;
      oRdValid            <= rdValidNext;
      oBusy               <= busyNext;
      oMemoryWriteAddress <= wrAddrNext;
      oMemoryReadAddress  <= rdAddrNext;
      oMemoryData         <= wrDataNext;
      oRdData             <= rdDataNext;
    end
  end

endmodule : sram_arbiter

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and randomized bench for sram_arbiter with an
// SRAM interface stub and a slot-scheduling reference model.
module tb_sram_arbiter;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;
  localparam int NC = 8192;

`ifdef SRAM_ARB_WR_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic          iCLK = 1'b0;
  logic          iRST;
  logic          iWrReq;
  logic [AW-1:0] iWrAddr;
  logic [DW-1:0] iWrData;
  logic          oWrAck;
  logic          iRdReq;
  logic [AW-1:0] iRdAddr;
  logic          oRdAck;
  logic [DW-1:0] oRdData;
  logic          oRdValid;
  logic          oControlState;
  logic [AW-1:0] oMemoryWriteAddress;
  logic [AW-1:0] oMemoryReadAddress;
  logic [DW-1:0] oMemoryData;
  logic [DW-1:0] iMemoryData = '0;
  logic          oBusy;

  int checks   = 0;
  int failures = 0;

  always #5 iCLK = ~iCLK;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .iCLK                (iCLK),
    .iRST                (iRST),
    .iWrReq              (iWrReq),
    .iWrAddr             (iWrAddr),
    .iWrData             (iWrData),
    .oWrAck              (oWrAck),
    .iRdReq              (iRdReq),
    .iRdAddr             (iRdAddr),
    .oRdAck              (oRdAck),
    .oRdData             (oRdData),
    .oRdValid            (oRdValid),
    .oControlState       (oControlState),
    .oMemoryWriteAddress (oMemoryWriteAddress),
    .oMemoryReadAddress  (oMemoryReadAddress),
    .oMemoryData         (oMemoryData),
    .iMemoryData         (iMemoryData),
    .oBusy               (oBusy)
  );

  // SRAM interface stub: writes when the slot is a write, registered read data.
  bit [DW-1:0] sram [0:(1<<AW)-1];
  always @(posedge iCLK) begin
    if (oControlState) sram[oMemoryWriteAddress] <= oMemoryData;
    iMemoryData <= sram[oMemoryReadAddress];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  function automatic logic [AW-1:0] rndAddr();
    if ($urandom_range(0, 7) == 0) return AW'(18'h3FFFF);
    return AW'($urandom_range(0, 15));
  endfunction

  // ---------------- reference model: slot scheduler ----------------
  bit          eCtrl    [0:NC-1];
  bit          eWrAck   [0:NC-1];
  bit          eRdAck   [0:NC-1];
  bit          eRdValid [0:NC-1];
  bit          eBusy    [0:NC-1];
  bit          eRst     [0:NC-1];
  bit          eWaSet   [0:NC-1];
  bit          eRaSet   [0:NC-1];
  logic [AW-1:0] eWa    [0:NC-1];
  logic [AW-1:0] eRa    [0:NC-1];
  logic [DW-1:0] eWd    [0:NC-1];
  logic [DW-1:0] eRdD   [0:NC-1];
  logic [DW-1:0] mm [int];

  logic [AW-1:0] curWa = '0;
  logic [AW-1:0] curRa = '0;
  logic [DW-1:0] curWd = '0;
  logic [DW-1:0] curRd = '0;
  int  cyc     = 0;
  bit  cmpEn   = 1'b0;
  int  nextArb = 0;
  bit  holdWr  = 1'b0;
  bit  lastWr  = 1'b0;

  always @(negedge iCLK) begin
    int a;
    if (cmpEn && cyc < NC) begin
      if (eRst[cyc]) begin
        curWa = '0; curWd = '0; curRa = '0; curRd = '0;
      end
      if (eWaSet[cyc]) begin curWa = eWa[cyc]; curWd = eWd[cyc]; end
      if (eRaSet[cyc]) curRa = eRa[cyc];
      if (eRdValid[cyc]) curRd = eRdD[cyc];
      chk("m_ctrl",    32'(oControlState), 32'(eCtrl[cyc]));
      chk("m_wrack",   32'(oWrAck),        32'(eWrAck[cyc]));
      chk("m_rdack",   32'(oRdAck),        32'(eRdAck[cyc]));
      chk("m_rdvalid", 32'(oRdValid),      32'(eRdValid[cyc]));
      chk("m_busy",    32'(oBusy),         32'(eBusy[cyc]));
      chk("m_wraddr",  32'(oMemoryWriteAddress), 32'(curWa));
      chk("m_wrdata",  32'(oMemoryData),   32'(curWd));
      chk("m_rdaddr",  32'(oMemoryReadAddress),  32'(curRa));
      chk("m_rddata",  32'(oRdData),       32'(curRd));
    end
    if (cyc + 8 < NC) begin
      if (iRST) begin
        for (int j = 1; j <= 6; j++) begin
          eCtrl[cyc+j] = 0; eWrAck[cyc+j] = 0; eRdAck[cyc+j] = 0;
          eRdValid[cyc+j] = 0; eBusy[cyc+j] = 0; eRst[cyc+j] = 0;
          eWaSet[cyc+j] = 0; eRaSet[cyc+j] = 0;
        end
        eRst[cyc+1] = 1'b1;
        nextArb = cyc + 1;
        holdWr  = 1'b0;
        lastWr  = 1'b0;
        cmpEn   = 1'b1;
      end else if (cmpEn && cyc >= nextArb) begin
        if (iWrReq && (!iRdReq || PRIO || !lastWr)) begin
          a = cyc + 1;
          eCtrl[a] = 1; eWrAck[a] = 1; eBusy[a] = 1; eBusy[a+1] = 1;
          eWaSet[a] = 1; eWa[a] = iWrAddr; eWd[a] = iWrData;
          mm[int'(iWrAddr)] = iWrData;
          nextArb = a + 1; holdWr = 1'b1; lastWr = 1'b1;
        end else if (iRdReq) begin
          a = cyc + 1 + (holdWr ? 1 : 0);
          if (holdWr) eBusy[cyc+1] = 1;
          eRdAck[a] = 1; eBusy[a] = 1; eBusy[a+1] = 1;
          eRaSet[a] = 1; eRa[a] = iRdAddr;
          eRdValid[a+2] = 1;
          eRdD[a+2] = mm.exists(int'(iRdAddr)) ? mm[int'(iRdAddr)] : '0;
          nextArb = a + 1; holdWr = 1'b0; lastWr = 1'b0;
        end else begin
          nextArb = cyc + 1; holdWr = 1'b0;
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus with literal expectations ----------------
  initial begin
    bit prevW;
    bit havePrev;
    iRST = 1'b1; iWrReq = 1'b0; iRdReq = 1'b0;
    iWrAddr = '0; iWrData = '0; iRdAddr = '0;
    prevW = 1'b0; havePrev = 1'b0;
    repeat (3) step();
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_ctrl", 32'(oControlState), 32'd0);
    chk("rst_rddata", 32'(oRdData), 32'd0);
    iRST = 1'b0;
    step();

    // Single write 0x00100 <- 0xBEEF
    iWrReq = 1'b1; iWrAddr = AW'(18'h00100); iWrData = DW'(16'hBEEF);
    step();
    chk("wr_ack", 32'(oWrAck), 32'd1);
    chk("wr_ctrl", 32'(oControlState), 32'd1);
    chk("wr_addr", 32'(oMemoryWriteAddress), 32'h00100);
    chk("wr_data", 32'(oMemoryData), 32'hBEEF);
    iWrReq = 1'b0;
    step();
    chk("wr_hold_ctrl", 32'(oControlState), 32'd0);
    chk("wr_hold_addr", 32'(oMemoryWriteAddress), 32'h00100);
    chk("wr_hold_data", 32'(oMemoryData), 32'hBEEF);
    step();
    chk("wr_idle_busy", 32'(oBusy), 32'd0);

    // Single read 0x00100
    iRdReq = 1'b1; iRdAddr = AW'(18'h00100);
    step();
    chk("rd_ack", 32'(oRdAck), 32'd1);
    chk("rd_addr", 32'(oMemoryReadAddress), 32'h00100);
    iRdReq = 1'b0;
    step();
    chk("rd_hold_valid", 32'(oRdValid), 32'd0);
    step();
    chk("rd_valid", 32'(oRdValid), 32'd1);
    chk("rd_data", 32'(oRdData), 32'hBEEF);

    // Write 0x3FFFF then read it: tie goes to write, then one TURN cycle
    iWrReq = 1'b1; iWrAddr = AW'(18'h3FFFF); iWrData = DW'(16'h1234);
    iRdReq = 1'b1; iRdAddr = AW'(18'h3FFFF);
    step();
    chk("ta_wrack", 32'(oWrAck), 32'd1);
    chk("ta_rdack_n1", 32'(oRdAck), 32'd0);
    iWrReq = 1'b0;
    step();
    step();
    chk("ta_turn_ctrl", 32'(oControlState), 32'd0);
    chk("ta_turn_rdack", 32'(oRdAck), 32'd0);
    chk("ta_turn_busy", 32'(oBusy), 32'd1);
    step();
    chk("ta_rdack", 32'(oRdAck), 32'd1);
    chk("ta_rdaddr", 32'(oMemoryReadAddress), 32'h3FFFF);
    iRdReq = 1'b0;
    step();
    step();
    chk("ta_valid", 32'(oRdValid), 32'd1);
    chk("ta_data", 32'(oRdData), 32'h1234);

    // Back-to-back writes 0..3, then back-to-back reads 0..3
    for (int i = 0; i < 4; i++) begin
      iWrReq = 1'b1; iWrAddr = AW'(i); iWrData = DW'(16'hA000 + i);
      if (i > 0) begin
        step();
        chk("b2b_wr_gap", 32'(oWrAck), 32'd0);
      end
      step();
      chk("b2b_wr_ack", 32'(oWrAck), 32'd1);
      chk("b2b_wr_addr", 32'(oMemoryWriteAddress), 32'(i));
    end
    iWrReq = 1'b0;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      iRdReq = 1'b1; iRdAddr = AW'(i);
      if (i > 0) begin
        step();
        chk("b2b_rd_gap", 32'(oRdAck), 32'd0);
      end
      step();
      chk("b2b_rd_ack", 32'(oRdAck), 32'd1);
      if (i > 0) begin
        chk("b2b_rd_valid", 32'(oRdValid), 32'd1);
        chk("b2b_rd_data", 32'(oRdData), 32'hA000 + 32'(i - 1));
      end
    end
    iRdReq = 1'b0;
    step();
    step();
    chk("b2b_rd_valid_last", 32'(oRdValid), 32'd1);
    chk("b2b_rd_data_last", 32'(oRdData), 32'hA003);

    // Reset while in RD_ACC
    iRdReq = 1'b1; iRdAddr = AW'(2);
    step();
    chk("rst_rdacc_ack", 32'(oRdAck), 32'd1);
    iRdReq = 1'b0; iRST = 1'b1;
    step();
    iRST = 1'b0;
    chk("rst_mid_ctrl", 32'(oControlState), 32'd0);
    chk("rst_mid_rdack", 32'(oRdAck), 32'd0);
    chk("rst_mid_busy", 32'(oBusy), 32'd0);
    chk("rst_mid_rdaddr", 32'(oMemoryReadAddress), 32'd0);
    chk("rst_mid_wraddr", 32'(oMemoryWriteAddress), 32'd0);
    chk("rst_mid_wrdata", 32'(oMemoryData), 32'd0);
    chk("rst_mid_rddata", 32'(oRdData), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("rst_mid_novalid", 32'(oRdValid), 32'd0);
      step();
    end

    // Both requests held continuously
    iWrReq = 1'b1; iWrAddr = rndAddr(); iWrData = DW'($urandom);
    iRdReq = 1'b1; iRdAddr = rndAddr();
    for (int c = 0; c < 40; c++) begin
      step();
      if (oWrAck || oRdAck) begin
`ifdef SRAM_ARB_WR_PRIORITY_EN
        chk("prio_wr_only", 32'(oWrAck), 32'd1);
`else
        if (havePrev) chk("rr_alternate", 32'(oWrAck), 32'(!prevW));
`endif
        prevW = oWrAck;
        havePrev = 1'b1;
      end
      if (oWrAck) begin iWrAddr = rndAddr(); iWrData = DW'($urandom); end
      if (oRdAck) iRdAddr = rndAddr();
    end
    iWrReq = 1'b0; iRdReq = 1'b0;
    repeat (6) step();

    // Randomized traffic with occasional resets
    for (int c = 0; c < 2000; c++) begin
      if (oWrAck) iWrReq = 1'b0;
      if (oRdAck) iRdReq = 1'b0;
      if (!iWrReq && $urandom_range(0, 99) < 40) begin
        iWrReq = 1'b1; iWrAddr = rndAddr(); iWrData = DW'($urandom);
      end
      if (!iRdReq && $urandom_range(0, 99) < 40) begin
        iRdReq = 1'b1; iRdAddr = rndAddr();
      end
      iRST = ($urandom_range(0, 199) == 0);
      step();
    end
    iRST = 1'b0; iWrReq = 1'b0; iRdReq = 1'b0;
    repeat (8) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sram_arbiter
